// File: rtl/gpio_irq_sched.sv
// gpio_irq_sched: pad synchroniser, edge/level pending latch and
// round-robin presenter sharing one CPU interrupt line among GPIO pins.
module gpio_irq_sched #(
    parameter int NSRC        = 16,
    parameter int SYNC_STAGES = 2,
    localparam int IDW        = $clog2(NSRC)
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic [NSRC-1:0] GPIO_IN,
    input  logic [NSRC-1:0] IRQ_EN,
    input  logic [NSRC-1:0] EDGE_MODE,
    input  logic            IRQ_ACK,
    output logic            CPU_IRQ,
    output logic [IDW-1:0]  IRQ_ID,
    output logic [NSRC-1:0] PENDING
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESENT = 2'd1;
    localparam logic [1:0] GAP     = 2'd2;

    logic [NSRC-1:0] sync_q [SYNC_STAGES];
    logic [NSRC-1:0] prev_q;
    logic [NSRC-1:0] s;
    logic [NSRC-1:0] set;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] pend_d;
    logic [1:0]      state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  id_inc;
    logic            found;
    logic            ack_hit;
    logic            withdrawn;
    int              idx;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= GPIO_IN;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            prev_q <= s;
        end
    end

    assign s   = sync_q[SYNC_STAGES-1];
    assign set = IRQ_EN & ((EDGE_MODE & s & ~prev_q) | (~EDGE_MODE & s));

    assign ack_hit   = (state == PRESENT) && IRQ_ACK;
    assign withdrawn = (state == PRESENT) && !IRQ_EN[IRQ_ID];
    assign ack_clr   = ack_hit ? ({{(NSRC-1){1'b0}}, 1'b1} << IRQ_ID) : '0;

    // A fresh set beats the ack clear so a coincident edge is not lost.
    assign pend_d = IRQ_EN & (set | (PENDING & ~ack_clr));

    assign id_inc = (IRQ_ID == IDW'(NSRC-1)) ? '0 : IRQ_ID + 1'b1;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NSRC; k++) begin
            idx = (int'(rr_ptr) + k) % NSRC;
            if (!found && PENDING[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= IDLE;
            CPU_IRQ <= 1'b0;
            IRQ_ID  <= '0;
            rr_ptr  <= '0;
            PENDING <= '0;
        end else begin
            PENDING <= pend_d;
            case (state)
                IDLE: begin
                    if (found) begin
                        IRQ_ID  <= winner;
                        CPU_IRQ <= 1'b1;
                        state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack_hit) begin
                        rr_ptr  <= id_inc;
                        CPU_IRQ <= 1'b0;
                        state   <= GAP;
                    end else if (withdrawn) begin
                        CPU_IRQ <= 1'b0;
                        state   <= GAP;
                    end
                end
                GAP: state <= IDLE;
                default: begin
                    CPU_IRQ <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_irq_sched.sv
// Bench for gpio_irq_sched: delay-line/queue model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_gpio_irq_sched;

    localparam int N = 16;
    localparam int S = 2;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic [N-1:0]  GPIO_IN = '0;
    logic [N-1:0]  IRQ_EN = '0;
    logic [N-1:0]  EDGE_MODE = '0;
    logic          IRQ_ACK = 1'b0;
    logic          CPU_IRQ;
    logic [3:0]    IRQ_ID;
    logic [N-1:0]  PENDING;

    int n_cmp = 0;
    int n_bad = 0;

    gpio_irq_sched #(.NSRC(N), .SYNC_STAGES(S)) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
        .GPIO_IN(GPIO_IN),
        .IRQ_EN(IRQ_EN),
        .EDGE_MODE(EDGE_MODE),
        .IRQ_ACK(IRQ_ACK),
        .CPU_IRQ(CPU_IRQ),
        .IRQ_ID(IRQ_ID),
        .PENDING(PENDING)
    );

    always #5 HCLK = ~HCLK;

    // Model: h[j] is the pad vector seen j+1 edges ago.
    logic [N-1:0] h [0:S];
    logic [N-1:0] m_pend = '0;
    bit           m_busy = 0;
    bit           m_gap = 0;
    int           m_id = 0;
    int           m_rr = 0;

    always @(posedge HCLK or posedge HRESET) begin : model
        logic [N-1:0] sv, pv, np;
        bit ack, st;
        int c;
        if (HRESET) begin
            for (int j = 0; j <= S; j++) h[j] = '0;
            m_pend = '0; m_busy = 0; m_gap = 0; m_id = 0; m_rr = 0;
        end else begin
            sv = h[S-1];
            pv = h[S];
            ack = m_busy && IRQ_ACK;
            np = '0;
            for (int i = 0; i < N; i++) begin
                st = IRQ_EN[i] && (EDGE_MODE[i] ? (sv[i] && !pv[i]) : sv[i]);
                if (!IRQ_EN[i]) np[i] = 0;
                else if (st) np[i] = 1;
                else if (ack && i == m_id) np[i] = 0;
                else np[i] = m_pend[i];
            end
            if (m_busy) begin
                if (ack) begin
                    m_rr = (m_id + 1) % N;
                    m_busy = 0; m_gap = 1;
                end else if (!IRQ_EN[m_id]) begin
                    m_busy = 0; m_gap = 1;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else if (m_pend != '0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    c = (m_rr + k) % N;
                    if (m_pend[c]) m_id = c;
                end
                m_busy = 1;
            end
            m_pend = np;
            for (int j = S; j > 0; j--) h[j] = h[j-1];
            h[0] = GPIO_IN;
        end
    end

    always @(negedge HCLK) begin
        if (!HRESET) begin
            n_cmp++;
            if (CPU_IRQ !== m_busy || IRQ_ID !== 4'(m_id) || PENDING !== m_pend) begin
                n_bad++;
                $display("FAIL model t=%0t: got irq=%0b id=%0d pend=%h, want irq=%0b id=%0d pend=%h",
                         $time, CPU_IRQ, IRQ_ID, PENDING, m_busy, m_id, m_pend);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        GPIO_IN = '0; IRQ_EN = '0; EDGE_MODE = '0; IRQ_ACK = 1'b0;
        tick(2);
        HRESET = 1'b0;
    endtask

    task automatic ack();
        IRQ_ACK = 1'b1;
        tick(1);
        IRQ_ACK = 1'b0;
    endtask

    task automatic wait_irq(input string name, input int exp_id);
        int i;
        for (i = 0; i < 20 && !CPU_IRQ; i++) tick(1);
        check({name, "_irq"}, 32'(CPU_IRQ), 32'd1);
        check({name, "_id"}, 32'(IRQ_ID), 32'(exp_id));
    endtask

    initial begin
        tick(2);
        check("rst_irq", 32'(CPU_IRQ), 0);
        check("rst_id", 32'(IRQ_ID), 0);
        check("rst_pend", 32'(PENDING), 0);
        HRESET = 1'b0;

        // Edge latency on source 5
        IRQ_EN[5] = 1; EDGE_MODE[5] = 1; GPIO_IN[5] = 1;
        tick(2);
        check("lat_pend_e1", 32'(PENDING), 0);
        tick(1);
        check("lat_pend_e2", 32'(PENDING), 32'h20);
        check("lat_irq_e2", 32'(CPU_IRQ), 0);
        tick(1);
        check("lat_irq_e3", 32'(CPU_IRQ), 1);
        check("lat_id_e3", 32'(IRQ_ID), 5);
        tick(3);
        check("lat_hold", 32'(CPU_IRQ), 1);
        ack();
        check("lat_ack_irq", 32'(CPU_IRQ), 0);
        check("lat_ack_pend", 32'(PENDING), 0);
        tick(5);
        check("lat_idle_irq", 32'(CPU_IRQ), 0);

        // Level re-assert on source 2
        do_reset();
        IRQ_EN[2] = 1; EDGE_MODE[2] = 0; GPIO_IN[2] = 1;
        tick(4);
        check("lvl_irq", 32'(CPU_IRQ), 1);
        check("lvl_id", 32'(IRQ_ID), 2);
        ack();
        check("lvl_gap", 32'(CPU_IRQ), 0);
        tick(1);
        check("lvl_idle", 32'(CPU_IRQ), 0);
        tick(1);
        check("lvl_re_irq", 32'(CPU_IRQ), 1);
        check("lvl_re_id", 32'(IRQ_ID), 2);
        GPIO_IN[2] = 0;
        tick(3);
        ack();
        tick(5);
        check("lvl_drop", 32'(CPU_IRQ), 0);

        // Round robin 3,7,3 then wrap after 15
        do_reset();
        IRQ_EN[3] = 1; IRQ_EN[7] = 1; EDGE_MODE[3] = 1; EDGE_MODE[7] = 1;
        GPIO_IN[3] = 1; GPIO_IN[7] = 1;
        wait_irq("rr_a", 3);
        ack();
        GPIO_IN[3] = 0;
        tick(2);
        GPIO_IN[3] = 1;
        wait_irq("rr_b", 7);
        ack();
        wait_irq("rr_c", 3);
        ack();
        do_reset();
        IRQ_EN[15] = 1; EDGE_MODE[15] = 1; GPIO_IN[15] = 1;
        wait_irq("wrap_a", 15);
        ack();
        IRQ_EN[0] = 1; IRQ_EN[14] = 1; EDGE_MODE[0] = 1; EDGE_MODE[14] = 1;
        GPIO_IN[0] = 1; GPIO_IN[14] = 1;
        wait_irq("wrap_b", 0);
        ack();
        wait_irq("wrap_c", 14);
        ack();

        // Withdraw source 9 while 4 waits
        do_reset();
        IRQ_EN[9] = 1; IRQ_EN[4] = 1; EDGE_MODE[9] = 1; EDGE_MODE[4] = 1;
        GPIO_IN[9] = 1;
        wait_irq("wd_a", 9);
        GPIO_IN[4] = 1;
        tick(3);
        IRQ_EN[9] = 0;
        tick(1);
        check("wd_irq", 32'(CPU_IRQ), 0);
        check("wd_pend", 32'(PENDING), 32'h10);
        wait_irq("wd_b", 4);
        ack();

        // Edge on 6 coinciding with its ack
        do_reset();
        IRQ_EN[6] = 1; EDGE_MODE[6] = 1; GPIO_IN[6] = 1;
        wait_irq("co_a", 6);
        GPIO_IN[6] = 0;
        tick(3);
        GPIO_IN[6] = 1;
        tick(2);
        ack();
        check("co_pend", 32'(PENDING), 32'h40);
        check("co_gap", 32'(CPU_IRQ), 0);
        tick(2);
        check("co_re_irq", 32'(CPU_IRQ), 1);
        check("co_re_id", 32'(IRQ_ID), 6);
        ack();

        // Async reset mid-presentation
        do_reset();
        IRQ_EN[11] = 1; EDGE_MODE[11] = 1; GPIO_IN[11] = 1;
        wait_irq("ar_a", 11);
        #2 HRESET = 1'b1;
        #1;
        check("ar_irq", 32'(CPU_IRQ), 0);
        check("ar_id", 32'(IRQ_ID), 0);
        check("ar_pend", 32'(PENDING), 0);
        GPIO_IN = '0; IRQ_EN = '0;
        tick(2);
        HRESET = 1'b0;
        tick(6);
        check("ar_quiet_irq", 32'(CPU_IRQ), 0);
        check("ar_quiet_pend", 32'(PENDING), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
